gnn_dense_layer_seq: RTL and testbench

Parametrised, time-multiplexed dense (fully-connected) layer engine for the GNN accelerator. It replaces fixed 4x4 / 4x2 hardwired multiply trees with one shared MAC that is reused across output channels. It accepts one node feature vector per transaction over a valid/ready handshake and streams OUT_DIM results over a valid/ready handshake. The weights live in an internal register file that is written through a simple write port while the engine is idle.

---
 rtl/gnn_dense_layer_seq.sv | 190 +++++++++++++++++++
 tb/tb_gnn_dense_layer_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_dense_layer_seq.sv
// gnn_dense_layer_seq
// Time-multiplexed dense layer engine. A single multiply-accumulate unit is
// reused across all output channels: each channel takes IN_DIM MAC cycles
// followed by one EMIT cycle (longer if the consumer stalls).
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   w_wr_en/addr/data     weight write port, address = j*IN_DIM + i; only
//                         honoured while idle and for in-range addresses
//   in_valid/in_ready     feature vector handshake, in_feat packs feature i
//                         at bits [i*DW +: DW]
//   out_valid/out_ready   result handshake, one result per output channel
//   out_data/out_idx      result value and its channel index
//   out_last              marks the result of channel OUT_DIM-1
//   busy                  high whenever a vector is in flight
//
// Build option: define GNN_ACC_SAT_EN to make the accumulator saturate at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.

module gnn_dense_layer_seq #(
  parameter int IN_DIM  = 4,
  parameter int OUT_DIM = 2,
  parameter int DW      = 5,
  parameter int ACC_W   = 20,
  localparam int NW     = IN_DIM * OUT_DIM,
  localparam int AW     = (NW > 1) ? $clog2(NW) : 1,
  localparam int IW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_wr_en,
  input  logic [AW-1:0]        w_wr_addr,
  input  logic [DW-1:0]        w_wr_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_DIM*DW-1:0] in_feat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic [IW-1:0]        out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int FW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  // Sum is one bit wider than both the accumulator and the raw product so
  // an overflow (or an over-wide product) is always visible as a carry.
  localparam int SW = ((ACC_W > 2 * DW) ? ACC_W : 2 * DW) + 1;
  localparam logic [AW:0]    W_CNT   = (AW + 1)'(NW);
  localparam logic [FW-1:0]  I_LAST  = FW'(IN_DIM - 1);
  localparam logic [IW-1:0]  J_LAST  = IW'(OUT_DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DW-1:0]          weight_r [NW];
  logic [IN_DIM*DW-1:0]   feat_r;
  logic [ACC_W-1:0]       acc_r;
  logic [ACC_W-1:0]       out_data_r;
  logic [FW-1:0]          i_r;
  logic [IW-1:0]          j_r;

  logic [AW-1:0]          rd_addr_s;
  logic [2*DW-1:0]        prod_s;
  logic [SW-1:0]          sum_s;
  logic [ACC_W-1:0]       acc_next_s;
  logic                   wr_ok_s;

  // MAC datapath: current product and the next accumulator value
  always_comb begin
    rd_addr_s  = AW'(j_r * IN_DIM) + AW'(i_r);
    prod_s     = feat_r[i_r*DW +: DW] * weight_r[rd_addr_s];
    sum_s      = SW'(acc_r) + SW'(prod_s);
`ifdef GNN_ACC_SAT_EN
    // Once saturated, every further nonzero add overflows again, so the
    // value stays pinned at the maximum until acc is cleared per channel.
    if (|sum_s[SW-1:ACC_W]) begin
      acc_next_s = {ACC_W{1'b1}};
    end else begin
      acc_next_s = sum_s[ACC_W-1:0];
    end
`else
    acc_next_s = ACC_W'(sum_s);
`endif
    wr_ok_s    = w_wr_en && (state_r == IDLE) && ({1'b0, w_wr_addr} < W_CNT);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (i_r == I_LAST) begin
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = MAC;
        end
      end
      EMIT: begin
        if (!out_ready) begin
          state_nxt_s = EMIT;
        end else if (j_r == J_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MAC;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from registered state and counters
  always_comb begin
    in_ready  = (state_r == IDLE);
    busy      = (state_r != IDLE);
    out_valid = (state_r == EMIT);
    out_last  = (state_r == EMIT) && (j_r == J_LAST);
    out_idx   = j_r;
    out_data  = out_data_r;
  end

  // Weight file, feature latch, counters and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) begin
        weight_r[k] <= '0;
      end
      feat_r     <= '0;
      acc_r      <= '0;
      out_data_r <= '0;
      i_r        <= '0;
      j_r        <= '0;
    end else begin
      if (wr_ok_s) begin
        weight_r[w_wr_addr] <= w_wr_data;
      end
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            feat_r <= in_feat;
            acc_r  <= '0;
            i_r    <= '0;
            j_r    <= '0;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (i_r == I_LAST) begin
            i_r        <= '0;
            out_data_r <= acc_next_s;
          end else begin
            i_r <= i_r + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready && (j_r != J_LAST)) begin
            j_r   <= j_r + 1'b1;
            i_r   <= '0;
            acc_r <= '0;
          end
        end
        default: begin
          acc_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnn_dense_layer_seq.sv
// Testbench for gnn_dense_layer_seq: two instances (default parameters, and
// a 4-in / 3-out / 8-bit accumulator variant for overflow and range cases),
// an arithmetic reference model with an expected-result queue per instance,
// and directed vectors with hand-computed literal results.

module tb_gnn_dense_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // instance 0: defaults
  logic        w_wr_en0;
  logic [2:0]  w_wr_addr0;
  logic [4:0]  w_wr_data0;
  logic        in_valid0, in_ready0;
  logic [19:0] in_feat0;
  logic        out_valid0, out_ready0;
  logic [19:0] out_data0;
  logic [0:0]  out_idx0;
  logic        out_last0, busy0;

  // instance 1: IN_DIM 4, OUT_DIM 3, ACC_W 8
  logic        w_wr_en1;
  logic [3:0]  w_wr_addr1;
  logic [4:0]  w_wr_data1;
  logic        in_valid1, in_ready1;
  logic [19:0] in_feat1;
  logic        out_valid1, out_ready1;
  logic [7:0]  out_data1;
  logic [1:0]  out_idx1;
  logic        out_last1, busy1;

  gnn_dense_layer_seq u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .w_wr_en(w_wr_en0), .w_wr_addr(w_wr_addr0), .w_wr_data(w_wr_data0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_feat(in_feat0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_idx(out_idx0), .out_last(out_last0), .busy(busy0)
  );

  gnn_dense_layer_seq #(.IN_DIM(4), .OUT_DIM(3), .DW(5), .ACC_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .w_wr_en(w_wr_en1), .w_wr_addr(w_wr_addr1), .w_wr_data(w_wr_data1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_feat(in_feat1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
  );

`ifdef GNN_ACC_SAT_EN
  localparam int OVF_EXP = 255;
`else
  localparam int OVF_EXP = 4;
`endif

  typedef struct packed {
    logic [19:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   m0_w[8];
  int   m1_w[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One channel of the layer: plain sum of products with wrap or clamp
  function automatic int expect_ch(input int f[4], input int w[4], input int acc_w);
    longint acc;
    longint lim;
    longint p;
    acc = 0;
    lim = longint'(1) << acc_w;
    for (int i = 0; i < 4; i++) begin
      p = longint'(f[i]) * longint'(w[i]);
`ifdef GNN_ACC_SAT_EN
      if (acc + p >= lim) acc = lim - 1;
      else acc = acc + p;
`else
      acc = (acc + p) % lim;
`endif
    end
    return int'(acc);
  endfunction

  function automatic logic [19:0] pack4(input int f[4]);
    return {5'(f[3]), 5'(f[2]), 5'(f[1]), 5'(f[0])};
  endfunction

  // Scoreboard: while a result is valid it must equal the head of the queue
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid0 === 1'b1) begin
        if (q0.size() == 0) begin
          check("sb0_unexpected_valid", 32'd1, 32'd0);
        end else begin
          check("sb0_data", 32'(out_data0), 32'(q0[0].data));
          check("sb0_idx", 32'(out_idx0), 32'(q0[0].idx));
          check("sb0_last", 32'(out_last0), 32'(q0[0].last));
          if (out_ready0 === 1'b1) void'(q0.pop_front());
        end
      end
      if (out_valid1 === 1'b1) begin
        if (q1.size() == 0) begin
          check("sb1_unexpected_valid", 32'd1, 32'd0);
        end else begin
          check("sb1_data", 32'(out_data1), 32'(q1[0].data));
          check("sb1_idx", 32'(out_idx1), 32'(q1[0].idx));
          check("sb1_last", 32'(out_last1), 32'(q1[0].last));
          if (out_ready1 === 1'b1) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic wr0(input int a, input int d, input bit idle);
    w_wr_en0 = 1'b1; w_wr_addr0 = 3'(a); w_wr_data0 = 5'(d);
    @(posedge clk); #1;
    w_wr_en0 = 1'b0;
    if (idle && a < 8) m0_w[a] = d;
  endtask

  task automatic wr1(input int a, input int d);
    w_wr_en1 = 1'b1; w_wr_addr1 = 4'(a); w_wr_data1 = 5'(d);
    @(posedge clk); #1;
    w_wr_en1 = 1'b0;
    if (a < 12) m1_w[a] = d;
  endtask

  // Push one vector's expected results for instance 0
  task automatic push0(input int f[4]);
    int   ws[4];
    exp_t e;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) ws[i] = m0_w[j*4 + i];
      e.data = 20'(expect_ch(f, ws, 20));
      e.idx  = 2'(j);
      e.last = (j == 1);
      q0.push_back(e);
    end
  endtask

  // Full transaction on instance 0 with timing checks; optional write while
  // busy and optional consumer stall on channel 0
  task automatic run0(input int f[4], input bit busy_wr, input int stall,
                      output logic [19:0] r0, output logic [19:0] r1);
    int k;
    k = 0;
    while (in_ready0 !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    check("in_ready_before_accept", 32'(in_ready0), 32'd1);
    in_valid0 = 1'b1; in_feat0 = pack4(f);
    push0(f);
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_feat0 = '0;
    check("in_ready_after_accept", 32'(in_ready0), 32'd0);
    check("busy_after_accept", 32'(busy0), 32'd1);
    if (busy_wr) begin w_wr_en0 = 1'b1; w_wr_addr0 = 3'd0; w_wr_data0 = 5'd31; end
    out_ready0 = (stall == 0);
    k = 0;
    while (out_valid0 !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; w_wr_en0 = 1'b0; end
    check("first_latency", 32'(k), 32'd4);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid_held", 32'(out_valid0), 32'd1);
    end
    out_ready0 = 1'b1;
    r0 = out_data0;
    check("ch0_idx", 32'(out_idx0), 32'd0);
    check("ch0_last", 32'(out_last0), 32'd0);
    @(posedge clk); #1;
    k = 0;
    while (out_valid0 !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    check("handshake_spacing", 32'(k + 1), 32'd5);
    r1 = out_data0;
    check("ch1_idx", 32'(out_idx0), 32'd1);
    check("ch1_last", 32'(out_last0), 32'd1);
    @(posedge clk); #1;
    check("in_ready_after_last", 32'(in_ready0), 32'd1);
    check("busy_after_last", 32'(busy0), 32'd0);
  endtask

  // Full transaction on instance 1 with out_ready held high
  task automatic run1(input int f[4], output logic [7:0] r0, output logic [7:0] r1,
                      output logic [7:0] r2);
    int          k;
    int          ws[4];
    exp_t        e;
    logic [7:0]  r[3];
    k = 0;
    while (in_ready1 !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    in_valid1 = 1'b1; in_feat1 = pack4(f);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) ws[i] = m1_w[j*4 + i];
      e.data = 20'(expect_ch(f, ws, 8));
      e.idx  = 2'(j);
      e.last = (j == 2);
      q1.push_back(e);
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      k = 0;
      while (out_valid1 !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
      check("v1_latency", 32'(k), 32'd4);
      r[c] = out_data1;
      @(posedge clk); #1;
    end
    check("v1_in_ready_after_last", 32'(in_ready1), 32'd1);
    r0 = r[0]; r1 = r[1]; r2 = r[2];
  endtask

  initial begin
    int f_a[4];
    int f_ovf[4];
    int f_one[4];
    logic [19:0] a0, a1;
    logic [7:0]  b0, b1, b2;
    f_a   = '{4, 2, 4, 1};
    f_ovf = '{31, 31, 31, 31};
    f_one = '{1, 1, 1, 1};
    for (int k = 0; k < 8; k++) m0_w[k] = 0;
    for (int k = 0; k < 12; k++) m1_w[k] = 0;

    rst_n = 1'b0;
    w_wr_en0 = 1'b0; w_wr_addr0 = '0; w_wr_data0 = '0;
    in_valid0 = 1'b0; in_feat0 = '0; out_ready0 = 1'b0;
    w_wr_en1 = 1'b0; w_wr_addr1 = '0; w_wr_data1 = '0;
    in_valid1 = 1'b0; in_feat1 = '0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_data", 32'(out_data0), 32'd0);
    check("rst_out_idx", 32'(out_idx0), 32'd0);
    check("rst_out_last", 32'(out_last0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // weights: ch0 {3,2,13,26}, ch1 {23,1,28,14}
    wr0(0, 3, 1'b1);  wr0(1, 2, 1'b1);  wr0(2, 13, 1'b1); wr0(3, 26, 1'b1);
    wr0(4, 23, 1'b1); wr0(5, 1, 1'b1);  wr0(6, 28, 1'b1); wr0(7, 14, 1'b1);

    // basic transaction
    run0(f_a, 1'b0, 0, a0, a1);
    check("t1_ch0", 32'(a0), 32'd94);
    check("t1_ch1", 32'(a1), 32'd220);

    // consumer stall of 5 cycles on channel 0
    run0(f_a, 1'b0, 5, a0, a1);
    check("t2_ch0", 32'(a0), 32'd94);
    check("t2_ch1", 32'(a1), 32'd220);

    // write while busy is dropped, same write when idle takes effect
    run0(f_a, 1'b1, 0, a0, a1);
    check("t3_busy_write_ch0", 32'(a0), 32'd94);
    wr0(0, 31, 1'b1);
    run0(f_a, 1'b0, 0, a0, a1);
    check("t3_idle_write_ch0", 32'(a0), 32'd206);
    check("t3_idle_write_ch1", 32'(a1), 32'd220);
    wr0(0, 3, 1'b1);

    // instance 1: all weights 31, then out-of-range writes must not matter
    for (int k = 0; k < 12; k++) wr1(k, 31);
    for (int k = 12; k < 16; k++) wr1(k, 0);
    run1(f_ovf, b0, b1, b2);
    check("t6_ovf_ch0", 32'(b0), 32'(OVF_EXP));
    check("t6_ovf_ch1", 32'(b1), 32'(OVF_EXP));
    check("t6_ovf_ch2", 32'(b2), 32'(OVF_EXP));
    run1(f_one, b0, b1, b2);
    check("t4_range_ch0", 32'(b0), 32'd124);
    check("t4_range_ch2", 32'(b2), 32'd124);

    // reset during channel 1 MAC aborts the transaction and clears weights
    in_valid0 = 1'b1; in_feat0 = pack4(f_a);
    push0(f_a);
    @(posedge clk); #1;
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    begin
      int k;
      k = 0;
      while (out_valid0 !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
      check("t5_first_latency", 32'(k), 32'd4);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_in_mac", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid0), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready0), 32'd1);
    check("t5_rst_busy", 32'(busy0), 32'd0);
    q0.delete();
    q1.delete();
    for (int k = 0; k < 8; k++) m0_w[k] = 0;
    for (int k = 0; k < 12; k++) m1_w[k] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run0(f_a, 1'b0, 0, a0, a1);
    check("t5_post_rst_ch0", 32'(a0), 32'd0);
    check("t5_post_rst_ch1", 32'(a1), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
